// File: rtl/calc_pkg.sv
// Shared definitions for the decimal calculator: FSM states, operator
// codes, command and status encodings, and width helpers.
package calc_pkg;

  typedef enum logic [2:0] {
    PRONTA,
    EXEC,
    CONV,
    SCAN,
    ERRO
  } state_t;

  // Operator codes match the low two bits of the operator commands.
  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_DIV = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  localparam logic [3:0] CMD_ADD  = 4'b1010;
  localparam logic [3:0] CMD_SUB  = 4'b1011;
  localparam logic [3:0] CMD_MUL  = 4'b1100;
  localparam logic [3:0] CMD_DIV  = 4'b1101;
  localparam logic [3:0] CMD_EQ   = 4'b1110;
  localparam logic [3:0] CMD_BKSP = 4'b1111;

  localparam logic [1:0] STATUS_ERRO    = 2'b00;
  localparam logic [1:0] STATUS_PRONTA  = 2'b01;
  localparam logic [1:0] STATUS_OCUPADA = 2'b10;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Smallest bit count able to hold every value below 10^ndig.
  function automatic int calc_width(input int ndig);
    longint unsigned lim;
    int w;
    lim = pow10(ndig);
    w = 0;
    while ((64'd1 << w) < lim) w++;
    return w;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, W cycles after
// start. done is high during the final step; bcd holds the full result
// from the following cycle until the next start.
module bin2bcd_seq #(
  parameter int W    = 27,
  parameter int NDIG = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  done,
  output logic [NDIG-1:0][3:0]  bcd
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * NDIG;

  logic [W-1:0]          sr;
  logic [CW-1:0]         cnt;
  logic                  busy;
  logic [NDIG-1:0][3:0]  adj;
  logic [BW-1:0]         bcd_n;

  // Add-3 correction on every digit of 5 or more, then shift the next bit in.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[i] >= 4'd5) adj[i] = bcd[i] + 4'd3;
    end
    bcd_n = BW'({adj, sr[W-1]});
  end

  assign done = busy && (cnt == CW'(W - 1));

  // Load on start, otherwise step the conversion while busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      bcd  <= '0;
    end else if (start) begin
      sr   <= bin;
      cnt  <= '0;
      busy <= 1'b1;
      bcd  <= '0;
    end else if (busy) begin
      sr  <= sr << 1;
      bcd <= bcd_n;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/calculadora_param.sv
// Decimal calculator: keys in two operands, runs add/sub/mul/div on equals,
// converts the magnitude to BCD and scans it out most significant first.
module calculadora_param
  import calc_pkg::*;
#(
  parameter  int NDIG = 8,
  localparam int W    = calc_width(NDIG),
  localparam int PW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic [1:0]    status,
  output logic [3:0]    dig,
  output logic [PW-1:0] pos,
  output logic          result_valid,
  output logic          neg
);

  localparam int W2 = 2 * W;
  localparam int CW = $clog2(W + 1);
  localparam logic [W2-1:0] MAXV = W2'(pow10(NDIG) - 64'd1);
  localparam logic [W-1:0]  LIM  = W'(pow10(NDIG - 1));

  state_t state, state_n;

  logic [W-1:0]          a, b, res, res_n;
  logic                  op_valid;
  op_t                   op;
  logic [W2-1:0]         m_acc, m_cand, mul_acc_n, res_wide;
  logic [W-1:0]          m_plier;
  logic [W-1:0]          d_rem, d_quo, div_quo_n, div_rem_n;
  logic [W:0]            div_shift;
  logic                  div_ge;
  logic [CW-1:0]         exec_cnt;
  logic [PW-1:0]         scan_cnt;
  logic                  accept, div_by_zero, exec_last, ovf, conv_start, conv_done;
  logic [NDIG-1:0][3:0]  bcd;

  assign cmd_ready   = (state == PRONTA) || (state == ERRO);
  assign accept      = cmd_valid && cmd_ready;
  assign div_by_zero = op_valid && (op == OP_DIV) && (b == '0);

  assign mul_acc_n = m_plier[0] ? (m_acc + m_cand) : m_acc;
  assign div_shift = {d_rem, d_quo[W-1]};
  assign div_ge    = div_shift >= {1'b0, b};
  assign div_rem_n = W'(div_ge ? (div_shift - {1'b0, b}) : div_shift);
  assign div_quo_n = {d_quo[W-2:0], div_ge};
  assign res_n     = W'(res_wide);

  bin2bcd_seq #(.W(W), .NDIG(NDIG)) u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (conv_start),
    .bin   (res_n),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= PRONTA;
    else       state <= state_n;
  end

  // Next state, status, and end-of-EXEC result selection with overflow check.
  always_comb begin
    state_n    = state;
    status     = STATUS_OCUPADA;
    exec_last  = 1'b0;
    res_wide   = '0;
    ovf        = 1'b0;
    conv_start = 1'b0;
    case (state)
      PRONTA: begin
        status = STATUS_PRONTA;
        if (accept && cmd == CMD_EQ) state_n = div_by_zero ? ERRO : EXEC;
      end
      EXEC: begin
        if (!op_valid || op == OP_ADD || op == OP_SUB) exec_last = 1'b1;
        else exec_last = (exec_cnt == CW'(W - 1));
        if (!op_valid) res_wide = W2'(a);
        else begin
          case (op)
            OP_ADD:  res_wide = W2'(a) + W2'(b);
            OP_SUB:  res_wide = (a >= b) ? W2'(a - b) : W2'(b - a);
            OP_MUL:  res_wide = mul_acc_n;
            default: res_wide = W2'(div_quo_n);
          endcase
        end
        if (exec_last) begin
          ovf        = res_wide > MAXV;
          state_n    = ovf ? ERRO : CONV;
          conv_start = !ovf;
        end
      end
      CONV: if (conv_done) state_n = SCAN;
      SCAN: if (scan_cnt == '0) state_n = PRONTA;
      ERRO: begin
        status = STATUS_ERRO;
        if (accept && cmd == CMD_BKSP) state_n = PRONTA;
      end
      default: state_n = PRONTA;
    endcase
  end

  // Operand entry, arithmetic iteration, result scan and display registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      a            <= '0;
      b            <= '0;
      res          <= '0;
      op_valid     <= 1'b0;
      op           <= OP_MUL;
      neg          <= 1'b0;
      m_acc        <= '0;
      m_cand       <= '0;
      m_plier      <= '0;
      d_rem        <= '0;
      d_quo        <= '0;
      exec_cnt     <= '0;
      scan_cnt     <= '0;
      dig          <= '0;
      pos          <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        PRONTA: begin
          if (accept) begin
            if (cmd <= 4'd9) begin
              dig <= cmd;
              pos <= '0;
              if (!op_valid) begin
                if (a < LIM) a <= a * W'(10) + W'(cmd);
              end else begin
                if (b < LIM) b <= b * W'(10) + W'(cmd);
              end
            end else if (cmd == CMD_EQ) begin
              neg      <= op_valid && (op == OP_SUB) && (a < b);
              exec_cnt <= '0;
              m_acc    <= '0;
              m_cand   <= W2'(a);
              m_plier  <= b;
              d_rem    <= '0;
              d_quo    <= a;
            end else if (cmd == CMD_BKSP) begin
              if (op_valid && b == '0) op_valid <= 1'b0;
              else if (op_valid)       b <= b / W'(10);
              else                     a <= a / W'(10);
            end else if (b == '0) begin
              op_valid <= 1'b1;
              op       <= op_t'(cmd[1:0]);
            end
          end
        end
        EXEC: begin
          exec_cnt <= exec_cnt + CW'(1);
          m_acc    <= mul_acc_n;
          m_cand   <= m_cand << 1;
          m_plier  <= m_plier >> 1;
          d_rem    <= div_rem_n;
          d_quo    <= div_quo_n;
          scan_cnt <= PW'(NDIG - 1);
          if (exec_last) res <= res_n;
        end
        SCAN: begin
          dig          <= bcd[scan_cnt];
          pos          <= scan_cnt;
          result_valid <= 1'b1;
          scan_cnt     <= scan_cnt - PW'(1);
          if (scan_cnt == '0) begin
            a        <= res;
            b        <= '0;
            op_valid <= 1'b0;
          end
        end
        ERRO: begin
          if (accept && cmd == CMD_BKSP) begin
            a        <= '0;
            b        <= '0;
            op_valid <= 1'b0;
            neg      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calculadora_param.sv
// Self-checking bench for calculadora_param (NDIG=8): a table of keyed
// sequences with hand-derived results, reset corner cases, and random
// sequences compared against an arithmetic reference model.
module tb_calculadora_param;

  localparam int     NDIG = 8;
  localparam int     W    = 27;
  localparam int     PW   = 3;
  localparam longint MAXV = 64'd99999999;
  localparam longint LIM  = 64'd10000000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    status;
  logic [3:0]    dig;
  logic [PW-1:0] pos;
  logic          result_valid;
  logic          neg;

  int    checks = 0;
  int    errors = 0;
  string curTag = "init";

  longint mA, mB;
  int     mOp;
  bit     mErr;

  typedef struct {
    int               n;
    logic [15:0][3:0] seq;
    bit               chain;
    longint           res;
    bit               negv;
    bit               err;
    int               lat;
  } vec_t;

  vec_t vecs[13];

  always #5 clock = ~clock;

  calculadora_param #(.NDIG(NDIG)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .status       (status),
    .dig          (dig),
    .pos          (pos),
    .result_valid (result_valid),
    .neg          (neg)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s/%s: got %0d expected %0d", curTag, name, act, exp);
    end
  endtask

  task automatic resetDut();
    @(negedge clock);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 4'd0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] c);
    int t;
    t = 0;
    @(negedge clock);
    while (!cmd_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!cmd_ready) checkOutput("cmdReadyWait", {63'd0, cmd_ready}, 64'd1);
    cmd       = c;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic runEquals(input longint expRes, input bit expNeg, input bit expErr, input int expLat);
    int     lat;
    bit     gotRv, gotErr;
    longint p;
    applyStimulus(4'b1110);
    lat = 0;
    gotRv = 1'b0;
    gotErr = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 1 && !expErr) begin
        checkOutput("busyStatus", status, 2'b10);
        checkOutput("busyReady", cmd_ready, 0);
      end
      if (result_valid) begin
        gotRv = 1'b1;
        lat = k;
        break;
      end
      if (status == 2'b00) begin
        gotErr = 1'b1;
        lat = k;
        break;
      end
    end
    if (expErr) begin
      checkOutput("errReached", gotErr, 1);
      checkOutput("errNoResult", gotRv, 0);
      checkOutput("errLatency", lat, expLat);
    end else begin
      checkOutput("resultSeen", gotRv, 1);
      checkOutput("resultLatency", lat, expLat);
      if (gotRv) begin
        for (int i = NDIG - 1; i >= 0; i--) begin
          p = 1;
          for (int j = 0; j < i; j++) p = p * 10;
          checkOutput("digit", dig, (expRes / p) % 10);
          checkOutput("digitPos", pos, i);
          checkOutput("digitValid", result_valid, 1);
          if (i > 0) @(negedge clock);
        end
      end
      checkOutput("negFlag", neg, expNeg);
      @(negedge clock);
      checkOutput("validDrop", result_valid, 0);
      checkOutput("backToPronta", status, 2'b01);
    end
  endtask

  task automatic modelCmd(input int c);
    if (mErr) begin
      if (c == 15) begin
        mA = 0; mB = 0; mOp = -1; mErr = 1'b0;
      end
    end else if (c <= 9) begin
      if (mOp < 0) begin
        if (mA < LIM) mA = mA * 10 + c;
      end else begin
        if (mB < LIM) mB = mB * 10 + c;
      end
    end else if (c == 15) begin
      if (mOp >= 0 && mB == 0) mOp = -1;
      else if (mOp >= 0)       mB = mB / 10;
      else                     mA = mA / 10;
    end else if (c >= 10 && c <= 13) begin
      if (mB == 0) mOp = c;
    end
  endtask

  task automatic modelEquals(output longint r, output bit ng, output bit er, output int lat);
    int e;
    ng = 1'b0;
    er = 1'b0;
    e = (mOp == 12 || mOp == 13) ? W : 1;
    case (mOp)
      10: r = mA + mB;
      11: begin
        if (mA >= mB) r = mA - mB;
        else begin r = mB - mA; ng = 1'b1; end
      end
      12: r = mA * mB;
      13: r = (mB == 0) ? 0 : mA / mB;
      default: r = mA;
    endcase
    if (mOp == 13 && mB == 0) begin
      er = 1'b1; lat = 1;
    end else if (r > MAXV) begin
      er = 1'b1; lat = e;
    end else begin
      lat = 1 + e + W;
      mA = r; mB = 0; mOp = -1;
    end
    mErr = er;
  endtask

  task automatic doCmd(input int c);
    applyStimulus(4'(c));
    modelCmd(c);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    longint r;
    bit     ng, er;
    int     lat, nd, nb;

    vecs[0]  = '{5,  64'h12A34,          1'b0, 46,       1'b0, 1'b0, 29};
    vecs[1]  = '{3,  64'h5B9,            1'b0, 4,        1'b1, 1'b0, 29};
    vecs[2]  = '{2,  64'hA1,             1'b1, 5,        1'b0, 1'b0, 29};
    vecs[3]  = '{5,  64'h100D7,          1'b0, 14,       1'b0, 1'b0, 55};
    vecs[4]  = '{3,  64'h7D0,            1'b0, 0,        1'b0, 1'b1, 1};
    vecs[5]  = '{12, 64'h9999999999C2,   1'b0, 0,        1'b0, 1'b1, 27};
    vecs[6]  = '{7,  64'h123FCF4,        1'b0, 124,      1'b0, 1'b0, 29};
    vecs[7]  = '{4,  64'h3AB5,           1'b0, 2,        1'b1, 1'b0, 29};
    vecs[8]  = '{1,  64'h8,              1'b0, 8,        1'b0, 1'b0, 29};
    vecs[9]  = '{4,  64'h2C5A,           1'b0, 10,       1'b0, 1'b0, 55};
    vecs[10] = '{9,  64'h9999C9999,      1'b0, 99980001, 1'b0, 1'b0, 55};
    vecs[11] = '{10, 64'h99999999A1,     1'b0, 0,        1'b0, 1'b1, 1};
    vecs[12] = '{3,  64'h9D2,            1'b0, 4,        1'b0, 1'b0, 55};

    curTag = "reset";
    resetDut();
    checkOutput("status", status, 2'b01);
    checkOutput("ready", cmd_ready, 1);
    checkOutput("dig", dig, 0);
    checkOutput("pos", pos, 0);
    checkOutput("valid", result_valid, 0);
    checkOutput("neg", neg, 0);

    curTag = "echo";
    applyStimulus(4'd7);
    checkOutput("echoDig", dig, 7);
    checkOutput("echoPos", pos, 0);
    checkOutput("echoValid", result_valid, 0);

    for (int i = 0; i < 13; i++) begin
      curTag = $sformatf("vec%0d", i);
      if (!vecs[i].chain) resetDut();
      for (int j = 0; j < vecs[i].n; j++) applyStimulus(vecs[i].seq[vecs[i].n - 1 - j]);
      runEquals(vecs[i].res, vecs[i].negv, vecs[i].err, vecs[i].lat);
      if (vecs[i].err) begin
        applyStimulus(4'd5);
        checkOutput("erroIgnoresDigit", status, 2'b00);
        applyStimulus(4'b1111);
        checkOutput("erroClear", status, 2'b01);
        runEquals(0, 1'b0, 1'b0, 29);
      end
    end

    curTag = "midExecReset";
    resetDut();
    applyStimulus(4'd3);
    applyStimulus(4'b1011);
    applyStimulus(4'd5);
    runEquals(2, 1'b1, 1'b0, 29);
    applyStimulus(4'b1100);
    applyStimulus(4'd4);
    applyStimulus(4'b1110);
    repeat (9) @(posedge clock);
    @(negedge clock);
    checkOutput("inExec", status, 2'b10);
    reset     = 1'b1;
    cmd       = 4'd5;
    cmd_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    reset     = 1'b0;
    checkOutput("status", status, 2'b01);
    checkOutput("ready", cmd_ready, 1);
    checkOutput("dig", dig, 0);
    checkOutput("pos", pos, 0);
    checkOutput("valid", result_valid, 0);
    checkOutput("neg", neg, 0);
    runEquals(0, 1'b0, 1'b0, 29);

    curTag = "random";
    resetDut();
    mA = 0; mB = 0; mOp = -1; mErr = 1'b0;
    for (int it = 0; it < 15; it++) begin
      curTag = $sformatf("rand%0d", it);
      nd = $urandom_range(0, 2);
      for (int j = 0; j < nd; j++) doCmd($urandom_range(0, 9));
      doCmd(10 + $urandom_range(0, 3));
      nb = $urandom_range(0, 4);
      for (int j = 0; j < nb; j++) doCmd($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) doCmd(15);
      modelEquals(r, ng, er, lat);
      runEquals(r, ng, er, lat);
      if (er) doCmd(15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
